// File: rtl/dot_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dot_op_scheduler
//  Description : Shares one combinational mul/div unit between two requesters.
//                Round-robin arbitration with one operation in flight. Unit
//                operands come from registers. The result is sampled after
//                SETTLE cycles and returned over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module dot_op_scheduler #(
  parameter int OPW    = 3,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  // Requester 0
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic               req0_op_i,
  input  logic [OPW-1:0]     req0_a_i,
  input  logic [OPW-1:0]     req0_b_i,
  // Requester 1
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic               req1_op_i,
  input  logic [OPW-1:0]     req1_a_i,
  input  logic [OPW-1:0]     req1_b_i,
  // Responses
  output logic               rsp0_valid_o,
  input  logic               rsp0_ready_i,
  output logic               rsp1_valid_o,
  input  logic               rsp1_ready_i,
  output logic [2*OPW-1:0]   rsp_data_o,
  output logic               rsp_dz_o,
  // Shared arithmetic unit
  output logic               unit_op_o,
  output logic [OPW-1:0]     unit_a_o,
  output logic [OPW-1:0]     unit_b_o,
  input  logic [2*OPW-1:0]   unit_result_i,
  // Status
  output logic               busy_o
);

  // Settle counter is wide enough for the full 1..15 SETTLE range.
  localparam int             CNTW           = 4;
  localparam logic [CNTW-1:0] C_SETTLE_LOAD = CNTW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t               state_q;
  logic                 last_q;      // last granted requester; also the one in flight
  logic [CNTW-1:0]      cnt_q;
  logic                 unit_op_q;
  logic [OPW-1:0]       unit_a_q;
  logic [OPW-1:0]       unit_b_q;
  logic [2*OPW-1:0]     rsp_data_q;
  logic                 rsp_dz_q;
  logic                 rsp0_valid_q;
  logic                 rsp1_valid_q;
  logic                 busy_q;

  logic                 w_grant;     // 0 = requester 0, 1 = requester 1
  logic                 w_accept;
  logic                 w_sel_op;
  logic [OPW-1:0]       w_sel_a;
  logic [OPW-1:0]       w_sel_b;
  logic                 w_rsp_taken;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_grant  = req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      w_grant = ~last_q;
    end
    w_accept = (state_q == S_IDLE) && (req0_valid_i || req1_valid_i);
    w_sel_op = w_grant ? req1_op_i : req0_op_i;
    w_sel_a  = w_grant ? req1_a_i  : req0_a_i;
    w_sel_b  = w_grant ? req1_b_i  : req0_b_i;
    // Only the in-flight requester's ready can close the response.
    w_rsp_taken = last_q ? rsp1_ready_i : rsp0_ready_i;
  end

  assign req0_ready_o = w_accept & ~w_grant;
  assign req1_ready_o = w_accept &  w_grant;

  // Scheduler FSM: accept, hold operands until settled, then hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      unit_op_q    <= 1'b0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      rsp_data_q   <= '0;
      rsp_dz_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            unit_op_q <= w_sel_op;
            unit_a_q  <= w_sel_a;
            unit_b_q  <= w_sel_b;
            last_q    <= w_grant;
            cnt_q     <= C_SETTLE_LOAD;
            busy_q    <= 1'b1;
            state_q   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            rsp_data_q   <= unit_result_i;
            rsp_dz_q     <= unit_op_q && (unit_b_q == '0);
            rsp0_valid_q <= ~last_q;
            rsp1_valid_q <=  last_q;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_taken) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_dz_o     = rsp_dz_q;
  assign unit_op_o    = unit_op_q;
  assign unit_a_o     = unit_a_q;
  assign unit_b_o     = unit_b_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_op_scheduler
//  Description : Directed self-checking bench for dot_op_scheduler with a
//                behavioural model of the shared mul/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_op_scheduler;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req0_op;
  logic [2:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_op;
  logic [2:0] req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [5:0] rsp_data;
  logic       rsp_dz;
  logic       unit_op;
  logic [2:0] unit_a, unit_b;
  logic [5:0] unit_result;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  dot_op_scheduler #(.OPW(3), .SETTLE(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid_i  (req0_valid),
    .req0_ready_o  (req0_ready),
    .req0_op_i     (req0_op),
    .req0_a_i      (req0_a),
    .req0_b_i      (req0_b),
    .req1_valid_i  (req1_valid),
    .req1_ready_o  (req1_ready),
    .req1_op_i     (req1_op),
    .req1_a_i      (req1_a),
    .req1_b_i      (req1_b),
    .rsp0_valid_o  (rsp0_valid),
    .rsp0_ready_i  (rsp0_ready),
    .rsp1_valid_o  (rsp1_valid),
    .rsp1_ready_i  (rsp1_ready),
    .rsp_data_o    (rsp_data),
    .rsp_dz_o      (rsp_dz),
    .unit_op_o     (unit_op),
    .unit_a_o      (unit_a),
    .unit_b_o      (unit_b),
    .unit_result_i (unit_result),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mul/div unit; divide by zero yields {3'b111, a}.
  always_comb begin
    logic [5:0] ea, eb;
    ea = {3'b000, unit_a};
    eb = {3'b000, unit_b};
    unit_result = ea * eb;
    if (unit_op) begin
      if (unit_b == 3'd0) unit_result = {3'b111, unit_a};
      else                unit_result = {unit_a / unit_b, unit_a % unit_b};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  // One complete operation from a single requester; called just after a falling edge.
  task automatic run_op(input int n, input logic op, input logic [2:0] a, input logic [2:0] b,
                        input logic [5:0] exp_data, input logic exp_dz, input string tag);
    if (n == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    #1;
    check({tag, "_ready0"}, req0_ready, n == 0);
    check({tag, "_ready1"}, req1_ready, n == 1);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    check({tag, "_busy"},   busy, 1);
    check({tag, "_unit_a"}, unit_a, a);
    check({tag, "_early"},  {rsp1_valid, rsp0_valid}, 0);
    @(negedge clk);
    check({tag, "_rsp0v"}, rsp0_valid, n == 0);
    check({tag, "_rsp1v"}, rsp1_valid, n == 1);
    check({tag, "_data"},  rsp_data, exp_data);
    check({tag, "_dz"},    rsp_dz, exp_dz);
    if (n == 0) rsp0_ready = 1; else rsp1_ready = 1;
    @(negedge clk);
    check({tag, "_done_v"},    {rsp1_valid, rsp0_valid}, 0);
    check({tag, "_done_busy"}, busy, 0);
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    // Reset state
    check("rst_busy",  busy, 0);
    check("rst_rspv",  {rsp1_valid, rsp0_valid}, 0);
    check("rst_data",  rsp_data, 0);
    check("rst_dz",    rsp_dz, 0);
    check("rst_unit",  {unit_op, unit_a, unit_b}, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    rst = 0;
    @(negedge clk);

    // 1: req0 multiply 3*5 = 15
    run_op(0, 1'b0, 3'd3, 3'd5, 6'b001111, 1'b0, "t1_mul");
    // 2: req1 divide 7/2 -> q=3 r=1
    run_op(1, 1'b1, 3'd7, 3'd2, 6'b011001, 1'b0, "t2_div");

    // 3: both valid after reset, held valid -> grants 0,1,0,1
    rst = 1;
    @(negedge clk);
    rst = 0;
    req0_valid = 1; req0_op = 0; req0_a = 3'd2; req0_b = 3'd3;
    req1_valid = 1; req1_op = 0; req1_a = 3'd4; req1_b = 3'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_ready0", req0_ready, (i % 2) == 0);
      check("t3_ready1", req1_ready, (i % 2) == 1);
      @(negedge clk);
      check("t3_unit_a", unit_a, ((i % 2) == 1) ? 3'd4 : 3'd2);
      @(negedge clk);
      check("t3_rsp0v", rsp0_valid, (i % 2) == 0);
      check("t3_rsp1v", rsp1_valid, (i % 2) == 1);
      check("t3_data",  rsp_data, ((i % 2) == 1) ? 6'd20 : 6'd6);
      rsp0_ready = 1; rsp1_ready = 1;
      #1;
      check("t3_resp_noready", {req1_ready, req0_ready}, 0);
      @(negedge clk);
      check("t3_done_v", {rsp1_valid, rsp0_valid}, 0);
      rsp0_ready = 0; rsp1_ready = 0;
    end
    idle_inputs();
    @(negedge clk);

    // 4: divide by zero flags dz and passes the unit output through
    run_op(0, 1'b1, 3'd5, 3'd0, 6'b111101, 1'b1, "t4_dz");
    // multiply by zero is not a divide-by-zero
    run_op(1, 1'b0, 3'd5, 3'd0, 6'd0, 1'b0, "t4_mulz");

    // 5: response held for 10 cycles while both requesters wait
    req0_valid = 1; req0_op = 0; req0_a = 3'd7; req0_b = 3'd7;
    #1;
    check("t5_ready0", req0_ready, 1);
    @(negedge clk);
    req1_valid = 1; req1_op = 1; req1_a = 3'd6; req1_b = 3'd3;
    rsp1_ready = 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("t5_rsp0v",  rsp0_valid, 1);
      check("t5_rsp1v",  rsp1_valid, 0);
      check("t5_data",   rsp_data, 6'd49);
      check("t5_busy",   busy, 1);
      check("t5_ready",  {req1_ready, req0_ready}, 0);
      @(negedge clk);
    end
    idle_inputs();
    rsp0_ready = 1;
    @(negedge clk);
    check("t5_release", {busy, rsp0_valid}, 0);
    rsp0_ready = 0;

    // 6: reset in SETTLE drops the op; req0 wins afterwards even though it was served last
    req0_valid = 1; req0_op = 0; req0_a = 3'd2; req0_b = 3'd2;
    @(negedge clk);
    req0_valid = 0;
    check("t6_settle_busy", busy, 1);
    check("t6_settle_a",    unit_a, 3'd2);
    rst = 1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rspv", {rsp1_valid, rsp0_valid}, 0);
    check("t6_rst_unit", {unit_op, unit_a, unit_b}, 0);
    @(negedge clk);
    rst = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    check("t6_ready0", req0_ready, 1);
    check("t6_ready1", req1_ready, 0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("t6_no_stale_rsp1", rsp1_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
